// File: rtl/core6_button_pio.sv
// Debounced button/switch PIO with an Avalon-MM slave: 2-flop synchronizer, per-bit
// stability counters, edge capture with write-1-to-clear, and a maskable level interrupt.
module core6_button_pio #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int             CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] debounced_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clear_mask;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [CW-1:0]    cnt [WIDTH];
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= IDLE_LEVEL;
      sync      <= IDLE_LEVEL;
    end else begin
      sync_meta <= in_port;
      sync      <= sync_meta;
    end
  end

  // The counter holds at most DEBOUNCE_CYCLES-1: the edge that would reach the
  // terminal count is the one that accepts the new level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      debounced <= IDLE_LEVEL;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == debounced[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_TC) begin
          debounced[i] <= sync[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) debounced_d <= IDLE_LEVEL;
    else          debounced_d <= debounced;
  end

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_det = debounced & ~debounced_d;
      1:       edge_det = ~debounced & debounced_d;
      default: edge_det = debounced ^ debounced_d;
    endcase
  end

  assign wr_en      = chipselect & ~write_n;
  assign clear_mask = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // A new edge ORs in after the clear so it survives a simultaneous W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
      irq_mask     <= '0;
    end else begin
      edge_capture <= (edge_capture & ~clear_mask) | edge_det;
      if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = debounced;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_core6_button_pio.sv
// Bench for core6_button_pio: directed scenarios plus random traffic, checked every
// cycle against a window-based debounce model and register-map model.
module tb_core6_button_pio;

  localparam int W   = 4;
  localparam int DEB = 4;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic [1:0]  address    = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = 32'd0;
  logic [W-1:0] in_port   = 4'hF;
  logic [31:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  core6_button_pio #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(1), .IDLE_LEVEL(4'hF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a level is accepted once the last DEB synchronized samples
  // all disagree with the current debounced level.
  logic [W-1:0] m_s1 = 4'hF, m_sync = 4'hF, m_deb = 4'hF, m_deb_d = 4'hF;
  logic [W-1:0] m_cap = '0, m_mask = '0, m_fall, m_clr, m_deb_next;
  logic [W-1:0] m_hist [DEB];
  logic [31:0]  m_rd = '0;
  logic         m_wr, m_flip;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = 4'hF; m_sync = 4'hF; m_deb = 4'hF; m_deb_d = 4'hF;
      m_cap = '0; m_mask = '0; m_rd = '0;
      for (int j = 0; j < DEB; j++) m_hist[j] = 4'hF;
    end else begin
      m_wr = chipselect && !write_n;
      case (address)
        2'd0:    m_rd = {28'd0, m_deb};
        2'd2:    m_rd = {28'd0, m_mask};
        2'd3:    m_rd = {28'd0, m_cap};
        default: m_rd = 32'd0;
      endcase
      m_fall = m_deb_d & ~m_deb;
      m_clr  = (m_wr && address == 2'd3) ? writedata[W-1:0] : '0;
      if (m_wr && address == 2'd2) m_mask = writedata[W-1:0];
      m_cap = (m_cap & ~m_clr) | m_fall;
      for (int j = DEB - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = m_sync;
      m_deb_next = m_deb;
      for (int i = 0; i < W; i++) begin
        m_flip = 1'b1;
        for (int j = 0; j < DEB; j++) if (m_hist[j][i] == m_deb[i]) m_flip = 1'b0;
        if (m_flip) m_deb_next[i] = ~m_deb[i];
      end
      m_deb_d = m_deb;
      m_deb   = m_deb_next;
      m_sync  = m_s1;
      m_s1    = in_port;
    end
  end

  initial for (int j = 0; j < DEB; j++) m_hist[j] = 4'hF;

  always @(negedge clk) begin
    if ($time > 0) begin
      check("readdata", readdata, m_rd);
      check("irq", 32'(irq), 32'(|(m_cap & m_mask)));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    idle(3);
    reset_n = 1'b1;
    check("rst_deb", 32'(dut.debounced), 32'hF);
    check("rst_cap", 32'(dut.edge_capture), 32'h0);
    check("rst_mask", 32'(dut.irq_mask), 32'h0);
    check("rst_rd", readdata, 32'h0);

    // clean press on bit 0
    address = 2'd0;
    idle(1);
    in_port = 4'hE;
    idle(5);
    check("press_early", 32'(dut.debounced), 32'hF);
    idle(1);
    check("press_deb", 32'(dut.debounced), 32'hE);
    check("press_cap_pre", 32'(dut.edge_capture), 32'h0);
    idle(1);
    check("press_cap", 32'(dut.edge_capture), 32'h1);
    check("press_rd", readdata, 32'hE);
    in_port = 4'hF;
    idle(10);
    check("release_no_edge", 32'(dut.edge_capture), 32'h1);
    wr(2'd3, 32'h0);
    check("w1c_zero", 32'(dut.edge_capture), 32'h1);
    wr(2'd3, 32'h1);
    check("w1c_clear", 32'(dut.edge_capture), 32'h0);

    // bounce
    in_port = 4'hE; idle(3);
    in_port = 4'hF; idle(1);
    in_port = 4'hE; idle(3);
    in_port = 4'hF; idle(10);
    check("bounce_deb", 32'(dut.debounced), 32'hF);
    check("bounce_cap", 32'(dut.edge_capture), 32'h0);

    // irq path
    wr(2'd2, 32'h1);
    in_port = 4'hE; idle(8);
    check("irq_set", 32'(irq), 32'h1);
    in_port = 4'hF; idle(8);
    wr(2'd3, 32'h1);
    check("irq_clear", 32'(irq), 32'h0);
    check("irq_cap_clear", 32'(dut.edge_capture), 32'h0);

    // masked bit
    in_port = 4'hB; idle(8);
    in_port = 4'hF; idle(8);
    check("masked_cap", 32'(dut.edge_capture), 32'h4);
    check("masked_irq", 32'(irq), 32'h0);
    wr(2'd2, 32'h4);
    check("unmask_irq", 32'(irq), 32'h1);
    wr(2'd3, 32'h4);
    check("unmask_clear", 32'(irq), 32'h0);

    // set wins over simultaneous W1C
    in_port = 4'hD; idle(6);
    check("setwin_deb", 32'(dut.debounced), 32'hD);
    check("setwin_pre", 32'(dut.edge_capture), 32'h0);
    wr(2'd3, 32'h2);
    check("setwin_cap", 32'(dut.edge_capture), 32'h2);
    in_port = 4'hF; idle(8);
    wr(2'd3, 32'h2);
    check("setwin_clear", 32'(dut.edge_capture), 32'h0);

    // reset mid-count
    wr(2'd2, 32'h3);
    address = 2'd2;
    in_port = 4'hE; idle(5);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_deb", 32'(dut.debounced), 32'hF);
    check("midrst_mask", 32'(dut.irq_mask), 32'h0);
    check("midrst_rd", readdata, 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    idle(2);
    reset_n = 1'b1;
    idle(5);
    check("midrst_early", 32'(dut.debounced), 32'hF);
    idle(1);
    check("midrst_deb_after", 32'(dut.debounced), 32'hE);

    // random traffic
    in_port = 4'hF;
    idle(10);
    wr(2'd3, 32'hF);
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) begin
        in_port = 4'($urandom);
        idle($urandom_range(1, 10));
      end else if (r < 7) begin
        wr(2'($urandom), $urandom);
      end else begin
        address = 2'($urandom);
        idle($urandom_range(1, 3));
      end
    end
    idle(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/core6_button_pio.md
CORE6_BUTTON_PIO -- requirements
Module: core6_button_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of input bits, 1..32.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to accept a level change, minimum 2.
REQ-003 SHALL have parameter EDGE_TYPE, default 1: capture edge select; 0 = rising, 1 = falling, 2 = any.
REQ-004 SHALL have parameter IDLE_LEVEL, default all ones: reset value of the synchronizer and debounce stages.
REQ-005 clk  input  1  clock; all logic SHALL be on its rising edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 address  input  2  Avalon-MM word address.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 writedata  input  32  write data.
REQ-011 in_port  input  WIDTH  asynchronous external inputs (keys/switches).
REQ-012 readdata  output  32  registered read data; read latency 1.
REQ-013 irq  output  1  active-high level interrupt.

Function
REQ-014 in_port SHALL pass through a 2-flop synchronizer per bit (sync).
REQ-015 Each bit SHALL have a counter of ceil(log2(DEBOUNCE_CYCLES+1)) bits.
REQ-016 Counter behaviour: sync == debounced -> clear; sync != debounced -> increment.
REQ-017 When a bit's counter reaches DEBOUNCE_CYCLES, debounced SHALL take the sync value on the same clock edge, and the counter SHALL clear.
REQ-018 Any bounce back to the debounced level before the count completes SHALL clear the counter; debounced SHALL NOT change.
REQ-019 debounced_d SHALL hold debounced delayed by one cycle.
REQ-020 An edge SHALL be detected when debounced differs from debounced_d and matches EDGE_TYPE.
REQ-021 On an edge, edge_capture[i] SHALL set on the next clock.
REQ-022 edge_capture[i] SHALL stay set until cleared by software.
REQ-023 Register map, address 0: read gives debounced, zero-extended; writes ignored.
REQ-024 Register map, address 1: reads 0; writes ignored.
REQ-025 Register map, address 2: irq_mask, read/write, bits [WIDTH-1:0].
REQ-026 Register map, address 3: edge_capture; read returns it; write is write-1-to-clear per bit.
REQ-027 A write SHALL occur when chipselect=1 and write_n=0; it SHALL take effect on that clock edge.
REQ-028 readdata SHALL be registered every cycle from the current address mux, independent of chipselect.
REQ-029 readdata upper bits [31:WIDTH] SHALL always read 0.
REQ-030 A new edge and a W1C clear of the same bit in the same cycle SHALL leave the bit set (set wins).
REQ-031 irq SHALL equal OR of (edge_capture & irq_mask), with no extra register stage.
REQ-032 A mask change SHALL affect irq the cycle after the write.
REQ-033 Writing 0 to a W1C bit SHALL leave it unchanged.

Reset
REQ-034 While reset_n=0, the following SHALL be forced: sync, debounced and debounced_d = IDLE_LEVEL; counters = 0; irq_mask = 0; edge_capture = 0; readdata = 0; irq = 0.
REQ-035 Reset assertion mid-debounce SHALL discard the partial count.
REQ-036 Release from reset with in_port == IDLE_LEVEL SHALL generate no edge.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1, IDLE_LEVEL=4'hF)
REQ-037 Clean press: in_port 4'hF -> 4'hE, held -> debounced[0]=0 exactly 2+4 cycles after the change; edge_capture=4'h1 one cycle later; address 0 read returns 32'hE.
REQ-038 Bounce: in_port[0] low 3 cycles, high 1 cycle, low 3 cycles -> debounced stays 4'hF, edge_capture stays 0.
REQ-039 IRQ path: mask=4'h1, press bit 0 -> irq=1; write 32'h1 to address 3 -> irq=0 next cycle, edge_capture=0.
REQ-040 Masked bit: mask=4'h1, press and release bit 2 -> edge_capture=4'h4, irq stays 0; write mask=4'h4 -> irq=1 next cycle.
REQ-041 Set wins: edge on bit 1 in the same cycle as a W1C write of 32'h2 -> edge_capture[1]=1 afterwards.
REQ-042 Reset mid-count: assert reset_n at count 3 of a press -> all registers at reset values; after release with in_port still 4'hE, a full 2+4 cycles elapse before debounced=4'hE.
